axis_pack_arbiter: RTL
======================

Name: axis_pack_arbiter

Overview:
Round-robin scheduler that shares one AXIS C2H record packer between NUM_SRC record producers. It grants one producer at a time and registers that producer's DATA_WIDTH record onto the packer's data/data_valid input. It tracks the packer's data_next handshake through accept and completion, then moves to the next producer. It sits between the core-side trace sources and the packer, in the m_axis_c2h_aclk domain.

Parameters:
NUM_SRC, 4, number of requesting producers (>=2).
DATA_WIDTH, 4064, record width, equal to the packer's DATA_WIDTH.
WDOG_CYCLES, 4096, watchdog limit in cycles; used only with ARB_WDOG_EN.
SRC_W, $clog2(NUM_SRC), localparam, width of grant_id.

Ports:
m_axis_c2h_aclk  in  1  sole clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-high.
src_valid  in  NUM_SRC  producer i has a record ready; held until src_ack[i].
src_data  in  NUM_SRC*DATA_WIDTH  record i at bits [i*DATA_WIDTH +: DATA_WIDTH].
src_en  in  NUM_SRC  per-producer enable mask; a cleared bit removes that producer from arbitration.
src_ack  out  NUM_SRC  one-cycle pulse: packer accepted producer i's record.
pk_data_valid  out  1  record valid to packer.
pk_data  out  DATA_WIDTH  registered record to packer.
pk_data_next  in  1  packer ready/idle; falls on accept, rises when the last beat is sent.
grant_id  out  SRC_W  index of the current or last granted producer.
busy  out  1  high whenever state != IDLE.
wdog_err  out  1  sticky watchdog error; constant 0 without ARB_WDOG_EN.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, and all outputs 0 (pk_data_valid, pk_data, src_ack, grant_id, busy, wdog_err). Reset mid-transfer aborts with no src_ack. The packer is reset by its own reset.
- req = src_valid & src_en.
- IDLE:
  - If pk_data_next==1 and req!=0, pick the first set bit of req scanning from rr_ptr upward, wrapping modulo NUM_SRC.
  - Register grant_id, pk_data<=src_data[grant], pk_data_valid<=1, and go to ISSUE.
  - Latency from src_valid to pk_data_valid is 1 cycle.
  - If pk_data_next==0, no grant is made.
- ISSUE:
  - Hold pk_data_valid=1 and pk_data stable until pk_data_next==0 is sampled.
  - Then pk_data_valid<=0, src_ack[grant_id]<=1 for exactly one cycle, and go to WAIT_DONE.
- WAIT_DONE: wait for pk_data_next==1, then go to GAP and set rr_ptr<=(grant_id+1) mod NUM_SRC.
- GAP: one cycle, covering the packer's post-send housekeeping cycle, then IDLE. Back-to-back records therefore have at least 2 idle cycles between pk_data_next rising and the next pk_data_valid.
- A producer dropping src_valid, or src_en changing, after the grant does not affect the current transfer. The mask applies at the next IDLE decision.
- If the granted producer has src_valid still high after src_ack, that is a new record. Round-robin still gives other requesters priority.
- Only one src_ack bit is ever high in a cycle.
- busy is combinational from state.

Optional Feature:
ARB_WDOG_EN:
- Defined:
  - A counter clears on entering ISSUE and increments each cycle in ISSUE or WAIT_DONE.
  - When it reaches WDOG_CYCLES: wdog_err<=1 (sticky until rst), pk_data_valid<=0, rr_ptr advances past grant_id, and state goes to GAP.
  - No src_ack is issued if expiry happens in ISSUE.
- Undefined: no counter exists, wdog_err is tied 0, and the block waits indefinitely.

Decomposition:
- Shared package/header axis_pack_defs holds:
  - state encodings IDLE, ISSUE, WAIT_DONE and GAP (2-bit);
  - the default WDOG_CYCLES;
  - the helper for the SRC_W width.
- Sub-module axis_rr_pick is combinational. Inputs are req[NUM_SRC] and ptr[SRC_W]; outputs are any and idx[SRC_W]. It implements the rotate, priority-encode and unrotate pick.

Test Plan:
1. Packer model (data_next falls 1 cycle after valid, rises 5 cycles later). Only src_valid[2]=1 with data=0xABC -> next cycle pk_data_valid=1, pk_data=0xABC, grant_id=2; src_ack=4'b0100 for 1 cycle after data_next falls.
2. All src_valid=4'b1111, continuously re-asserted -> grant order 0,1,2,3,0,1; each src_ack a single pulse.
3. src_en=4'b1011, all valid -> order 0,1,3,0; src_ack[2] never asserts.
4. pk_data_next held 0 for 20 cycles after reset with src_valid[0]=1 -> pk_data_valid stays 0, busy=0; grant occurs on the cycle after data_next rises.
5. rst pulsed while in WAIT_DONE for grant 1 -> next cycle all outputs 0; with all valid, the first grant after reset is 0.
6. ARB_WDOG_EN, WDOG_CYCLES=16, packer never drops data_next, src_valid=4'b0011 -> after 16 ISSUE cycles wdog_err=1, no src_ack[0]; next grant_id=1; wdog_err stays 1 until rst.

Source files
------------

// File: rtl/axis_pack_arbiter_pkg.sv
// Shared definitions for the C2H packer arbiter: FSM state encoding,
// default watchdog limit and the grant-index width helper.
package axis_pack_defs;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;

    localparam int WDOG_CYCLES_DEF = 4096;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pack_arbiter_rr_pick.sv
// Round-robin pick: first set req bit at or above ptr, wrapping modulo NUM_SRC.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of req and ptr.
module axis_rr_pick
    import axis_pack_defs::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic               any,
    output logic [SRC_W-1:0]   idx
);

    localparam logic [SRC_W:0] N_EXT = (SRC_W+1)'(NUM_SRC);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    logic [SRC_W-1:0]     off;
    logic [SRC_W:0]       sum;

    // Rotate so that bit 0 of rot corresponds to requester ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NUM_SRC-1:0];
    assign any = |rot;

    always_comb begin
        off = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = SRC_W'(j);
            end
        end
    end

    assign sum = {1'b0, ptr} + {1'b0, off};
    assign idx = (sum >= N_EXT) ? SRC_W'(sum - N_EXT) : sum[SRC_W-1:0];

endmodule

// File: rtl/axis_pack_arbiter.sv
// Round-robin scheduler sharing one AXIS C2H record packer among NUM_SRC producers.
// Latency: 1 cycle from src_valid to pk_data_valid; at least 2 idle cycles after pk_data_next rises.
// Backpressure: grants only while pk_data_next=1; holds the record until the packer drops data_next. ARB_WDOG_EN adds a stall watchdog.
module axis_pack_arbiter
    import axis_pack_defs::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int DATA_WIDTH  = 4064,
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
    localparam int SRC_W      = idx_width(NUM_SRC)
) (
    input  logic                          m_axis_c2h_aclk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_en,
    output logic [NUM_SRC-1:0]            src_ack,
    output logic                          pk_data_valid,
    output logic [DATA_WIDTH-1:0]         pk_data,
    input  logic                          pk_data_next,
    output logic [SRC_W-1:0]              grant_id,
    output logic                          busy,
    output logic                          wdog_err
);

    arb_state_t            state, state_n;
    logic [SRC_W-1:0]      rr_ptr, rr_ptr_n;
    logic [SRC_W-1:0]      grant_n, grant_inc, pick_idx;
    logic                  pick_any;
    logic                  vld_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [NUM_SRC-1:0]    ack_n;
    logic [NUM_SRC-1:0]    req;
    logic                  expire;
    logic [DATA_WIDTH-1:0] src_rec [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_rec
        assign src_rec[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign req       = src_valid & src_en;
    assign busy      = (state != IDLE);
    assign grant_inc = (grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id + SRC_W'(1);

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_err_q;

    // Fires on the cycle whose count increment would reach the limit.
    assign expire = ((state == ISSUE) || (state == WAIT_DONE)) &&
                    (wd_cnt == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            wd_cnt   <= '0;
            wd_err_q <= 1'b0;
        end else begin
            if ((state == IDLE) && (state_n == ISSUE)) begin
                wd_cnt <= '0;
            end else if ((state == ISSUE) || (state == WAIT_DONE)) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (expire) begin
                wd_err_q <= 1'b1;
            end
        end
    end

    assign wdog_err = wd_err_q;
`else
    assign expire   = 1'b0;
    assign wdog_err = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        grant_n  = grant_id;
        vld_n    = pk_data_valid;
        data_n   = pk_data;
        ack_n    = '0;
        case (state)
            IDLE: begin
                if (pk_data_next && pick_any) begin
                    grant_n = pick_idx;
                    data_n  = src_rec[pick_idx];
                    vld_n   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!pk_data_next) begin
                    vld_n           = 1'b0;
                    ack_n[grant_id] = 1'b1;
                    state_n         = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (pk_data_next) begin
                    rr_ptr_n = grant_inc;
                    state_n  = GAP;
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // A stalled packer abandons the record without acknowledging it.
        if (expire) begin
            vld_n    = 1'b0;
            ack_n    = '0;
            rr_ptr_n = grant_inc;
            state_n  = GAP;
        end
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_id      <= '0;
            pk_data_valid <= 1'b0;
            pk_data       <= '0;
            src_ack       <= '0;
        end else begin
            state         <= state_n;
            rr_ptr        <= rr_ptr_n;
            grant_id      <= grant_n;
            pk_data_valid <= vld_n;
            pk_data       <= data_n;
            src_ack       <= ack_n;
        end
    end

endmodule
